// File: rtl/rca_16.sv
// ----------------------------------------------------------------------------
// rca_16 : registered ripple-carry adder, {cout, S} = A + B + cin.
//
// The combinational core is a chain of WIDTH one-bit full adders with no
// lookahead; carry c(i+1) of stage i feeds stage i+1. Sum, carry-out and
// signed overflow are captured in an output register one cycle after a valid
// operand set. Cycles with in_valid low hold the previous result and drop
// out_valid.
//
// Ports (rca_16):
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset
//   in_valid   in   A/B/cin valid this cycle
//   A, B       in   WIDTH-bit unsigned addends
//   cin        in   carry into bit 0
//   S          out  registered sum (modulo 2^WIDTH)
//   cout       out  registered carry out of the MSB
//   ovf        out  registered two's-complement overflow
//   out_valid  out  S/cout/ovf hold a result from a valid operand set
//
// Ports (rca_fa):
//   a_i, b_i, c_i  in   addend bits and carry-in
//   s_o, c_o       out  sum bit and carry-out (combinational)
// ----------------------------------------------------------------------------

// One-bit full adder cell.
module rca_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module rca_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int unsigned MSB = WIDTH - 1;

  // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;

  // Result register and its next-state values.
  logic [WIDTH-1:0] s_q,     s_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             valid_q, valid_d;

  assign carry[0] = cin;

  // Ripple chain: each stage consumes the carry produced by the stage below.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    rca_fa u_fa (
      .a_i (A[i]),
      .b_i (B[i]),
      .c_i (carry[i]),
      .s_o (sum_c[i]),
      .c_o (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign ovf_c = carry[MSB] ^ carry[WIDTH];

  // Next-state: capture on valid, otherwise hold the result and clear valid.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (in_valid) begin
      s_d     = sum_c;
      cout_d  = carry[WIDTH];
      ovf_d   = ovf_c;
      valid_d = 1'b1;
    end
  end

  // Output register; reset discards any operation presented alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= WIDTH'(0);
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rca_16.sv
// ----------------------------------------------------------------------------
// tb_rca_16 : self-checking bench for rca_16.
// A behavioural model computes the expected registered outputs from plain
// integer arithmetic each rising edge; a compare process checks the DUT on
// every falling edge. Directed rows additionally pin literal expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rca_16;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int checks;
  int errors;

  // Model state.
  logic [W-1:0] exp_s;
  logic         exp_cout;
  logic         exp_ovf;
  logic         exp_valid;
  logic         model_ok;

  rca_16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .cin       (cin),
    .S         (s),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer add, signed range check for overflow.
  always @(posedge clk) begin
    int unsigned usum;
    int          ssum;
    usum = int'(a) + int'(b) + int'(cin);
    ssum = int'($signed(a)) + int'($signed(b)) + int'(cin);
    if (rst) begin
      exp_s     <= '0;
      exp_cout  <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_valid <= 1'b0;
    end else if (in_valid) begin
      exp_s     <= W'(usum);
      exp_cout  <= (usum > 32'd65535);
      exp_ovf   <= (ssum > 32767) || (ssum < -32768);
      exp_valid <= 1'b1;
    end else begin
      exp_valid <= 1'b0;
    end
    model_ok <= 1'b1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok === 1'b1) begin
      checks++;
      if (s !== exp_s || cout !== exp_cout || ovf !== exp_ovf || out_valid !== exp_valid) begin
        errors++;
        $display("FAIL model t=%0t got S=%h cout=%b ovf=%b vld=%b want S=%h cout=%b ovf=%b vld=%b",
                 $time, s, cout, ovf, out_valid, exp_s, exp_cout, exp_ovf, exp_valid);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
  endtask

  // Literal check of the current registered outputs.
  task automatic expect_lit(input string name, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ev);
    checks++;
    if (s !== es || cout !== ec || ovf !== eo || out_valid !== ev) begin
      errors++;
      $display("FAIL %s got S=%0d cout=%b ovf=%b vld=%b want S=%0d cout=%b ovf=%b vld=%b",
               name, s, cout, ovf, out_valid, es, ec, eo, ev);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } row_t;

  row_t rows[$];

  initial begin
    checks   = 0;
    errors   = 0;
    model_ok = 1'b0;
    rst      = 1'b1;
    drive(1'b1, 16'd1234, 16'd1, 1'b0);

    // Reset held two cycles with a valid operation present.
    @(negedge clk);
    @(negedge clk);
    expect_lit("reset0", 16'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_lit("reset1", 16'd0, 1'b0, 1'b0, 1'b0);

    rows.push_back('{16'd65000, 16'd65340, 1'b0, 16'd64804, 1'b1, 1'b0});
    rows.push_back('{16'd58135, 16'd3592,  1'b0, 16'd61727, 1'b0, 1'b0});
    rows.push_back('{16'd1005,  16'd69,    1'b1, 16'd1075,  1'b0, 1'b0});
    rows.push_back('{16'd15124, 16'd5383,  1'b1, 16'd20508, 1'b0, 1'b0});
    rows.push_back('{16'd50,    16'd10024, 1'b0, 16'd10074, 1'b0, 1'b0});
    rows.push_back('{16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1, 1'b0});
    rows.push_back('{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0});
    rows.push_back('{16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0, 1'b1});
    rows.push_back('{16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b1});
    rows.push_back('{16'd1,     16'd2,     1'b0, 16'd3,     1'b0, 1'b0});

    // Release reset with the first row; rows back-to-back, checked next cycle.
    rst = 1'b0;
    drive(1'b1, rows[0].a, rows[0].b, rows[0].c);
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk);
      expect_lit($sformatf("row%0d", i), rows[i].s, rows[i].co, rows[i].ov, 1'b1);
      if (i + 1 < rows.size())
        drive(1'b1, rows[i+1].a, rows[i+1].b, rows[i+1].c);
      else
        drive(1'b0, 16'hAAAA, 16'h5555, 1'b1);
    end

    // Hold: last row was 1+2=3; idle cycles with changing operands.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      expect_lit($sformatf("hold%0d", k), 16'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    end

    // Random regression with random valid and occasional reset.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_16.md
Name: rca_16

Overview:
- 16-bit ripple-carry adder: S = A + B + cin with carry-out.
- Combinational core is a chain of 16 one-bit full adders. Each stage's carry feeds the next; there is no lookahead.
- Core results are captured in an output register on the rising clock edge.
- Used as the basic registered adder datapath element. It is the baseline against which lookahead adders are compared.

Parameters:
- WIDTH, 16, operand/sum width. Only 16 is required to be supported; the generate-based chain must stay width-generic.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on A/B/cin are valid this cycle
- A  input  16  unsigned addend
- B  input  16  unsigned addend
- cin  input  1  carry-in to bit 0
- S  output  16  registered sum bits [15:0]
- cout  output  1  registered carry out of bit 15
- ovf  output  1  registered signed (two's-complement) overflow: carry into bit 15 XOR carry out of bit 15
- out_valid  output  1  S/cout/ovf hold a result produced from valid inputs

Behaviour:
- Core structure:
  - Full adder per bit: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin; cout = c_16.
  - Built as 16 instances of a full-adder submodule; no behavioural "+" in the core.
- Arithmetic:
  - {cout, S} = A + B + cin, evaluated as a 17-bit unsigned result.
  - Output range 0..131071.
  - No saturation: S wraps modulo 2^16.
- Latency and capture:
  - Exactly 1 cycle.
  - On the rising edge with rst=0 and in_valid=1, the register captures S, cout, ovf and sets out_valid=1.
  - On the rising edge with rst=0 and in_valid=0, S/cout/ovf hold their previous values and out_valid goes to 0.
- Throughput: one new operand set accepted per cycle. There is no backpressure and no ready signal.
- Reset:
  - On a rising edge with rst=1, S=0, cout=0, ovf=0, out_valid=0. This overrides in_valid.
  - An operation presented in the same cycle as rst is discarded.
  - First valid output appears one cycle after the first in_valid cycle with rst=0.
- Boundaries:
  - A=B=0xFFFF, cin=1 -> S=0xFFFF, cout=1 (maximum result).
  - A=0xFFFF, B=0, cin=1 -> full ripple through all 16 stages; S=0, cout=1.
  - Timing for the full ripple must close at the target clock.
- ovf is defined for signed interpretation only. It does not affect S/cout.
- No X propagation from in_valid=0 cycles: registered outputs simply hold.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, A=1234, B=1 -> S=0, cout=0, ovf=0, out_valid=0. First result appears the cycle after rst is released.
- Unsigned results with carry; each row is applied back-to-back, one per cycle with in_valid=1, and the result is checked one cycle later with out_valid=1:
  - A=65000, B=65340, cin=0 -> S=64804, cout=1
  - A=58135, B=3592, cin=0 -> S=61727, cout=0
  - A=1005, B=69, cin=1 -> S=1075, cout=0
  - A=15124, B=5383, cin=1 -> S=20508, cout=0
  - A=50, B=10024, cin=0 -> S=10074, cout=0
- Full ripple: A=0xFFFF, B=0x0000, cin=1 -> S=0x0000, cout=1, ovf=0. Then A=0xFFFF, B=0xFFFF, cin=1 -> S=0xFFFF, cout=1.
- Signed overflow:
  - A=0x7FFF, B=0x0001, cin=0 -> S=0x8000, cout=0, ovf=1.
  - A=0x8000, B=0x8000, cin=0 -> S=0x0000, cout=1, ovf=1.
- Hold behaviour: one valid add (A=1, B=2, cin=0 -> S=3), then in_valid=0 for 3 cycles with changing A/B -> S stays 3, out_valid=0 in those cycles.
- Random regression: 10k random A/B/cin with random in_valid -> every valid result equals the 17-bit reference A+B+cin, one cycle later.
